binaris_lefele_idozito: RTL and testbench

- Loadable, pausable binary down-counter/timer. It is the count-down counterpart of the design's free-running up counters.
- Counts from a programmed value to zero and emits a one-cycle terminal-count pulse.
- Supports one-shot or periodic (auto-reload) operation.
- Used as a general-purpose interval timer next to the existing counters.

---
 rtl/binaris_lefele_idozito.sv | 102 ++++++++++
 tb/tb_binaris_lefele_idozito.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/binaris_lefele_idozito.sv
// Loadable, pausable binary down-counter with one-shot or auto-reload operation.
// Latency: q and busy update one edge after load/start/stop; tc is registered, high in the cycle q shows 0 or R.
// Backpressure: none; load > stop > start > count on every edge, async active-high reset aborts immediately.
module binaris_lefele_idozito #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             start,
   input  logic             stop,
   input  logic             periodic,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             tc
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO = '0;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;

   // Next-state logic: load wins, then the per-state stop/start/count rules.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
      if (load) begin
         reload_d = d;
         count_d  = d;
         // A running timer loaded with zero has nothing left to count.
         if (state_q == RUN && d == ZERO) begin
            state_d = IDLE;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (start && count_q != ZERO) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (stop) begin
                  state_d = PAUSE;
               end else if (count_q > ONE) begin
                  count_d = count_q - ONE;
               end else if (count_q == ONE) begin
                  tc_d = 1'b1;
                  if (periodic && reload_q != ZERO) begin
                     count_d = reload_q;
                  end else begin
                     count_d = ZERO;
                     state_d = IDLE;
                  end
               end else begin
                  // Zero count while running (loaded 0 during PAUSE): finish quietly.
                  state_d = IDLE;
               end
            end
            PAUSE: begin
               if (start && !stop) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, count, reload and tc registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= ZERO;
         reload_q <= ZERO;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   assign q    = count_q;
   assign busy = (state_q != IDLE);
   assign tc   = tc_q;

endmodule

// File: tb/tb_binaris_lefele_idozito.sv
// Self-checking bench for binaris_lefele_idozito: vector table, corner sequences, random vs model.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that point too.
// The design has no backpressure; every edge is checked against the expectation.
module tb_binaris_lefele_idozito;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             load = 1'b0;
   logic [WIDTH-1:0] d = '0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             periodic = 1'b0;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             tc;

   int total = 0;
   int bad   = 0;

   binaris_lefele_idozito #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .d        (d),
      .start    (start),
      .stop     (stop),
      .periodic (periodic),
      .q        (q),
      .busy     (busy),
      .tc       (tc)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       ld;
      int       dv;
      bit       st;
      bit       sp;
      bit       per;
      int       eq;
      bit       eb;
      bit       et;
   } vec_t;

   vec_t vecs[$];

   // Reference model: plain integers, mode 0 = idle, 1 = counting, 2 = paused.
   int m_mode, m_cnt, m_rel;
   bit m_tc;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit ld, input int dv, input bit st, input bit sp, input bit per);
      load     = ld;
      d        = WIDTH'(dv);
      start    = st;
      stop     = sp;
      periodic = per;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_mode = 0; m_cnt = 0; m_rel = 0; m_tc = 0;
   endtask

   task automatic model_step(input bit ld, input int dv, input bit st, input bit sp, input bit per);
      m_tc = 0;
      if (ld) begin
         m_rel = dv;
         m_cnt = dv;
         if (m_mode == 1 && dv == 0) m_mode = 0;
      end else if (m_mode == 0) begin
         if (st && m_cnt != 0) m_mode = 1;
      end else if (m_mode == 2) begin
         if (st && !sp) m_mode = 1;
      end else if (sp) begin
         m_mode = 2;
      end else if (m_cnt == 0) begin
         m_mode = 0;
      end else begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) begin
            m_tc = 1;
            if (per && m_rel != 0) m_cnt = m_rel;
            else m_mode = 0;
         end
      end
   endtask

   function automatic vec_t mk(bit ld, int dv, bit st, bit sp, bit per, int eq, bit eb, bit et);
      vec_t v;
      v.ld = ld; v.dv = dv; v.st = st; v.sp = sp; v.per = per;
      v.eq = eq; v.eb = eb; v.et = et;
      return v;
   endfunction

   initial begin
      int tc_edge;
      bit wrapped;
      bit seen_tc;

      // Reset state.
      reset = 1'b1;
      tick();
      tick();
      chk("reset_q", int'(q), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_tc", int'(tc), 0);
      reset = 1'b0;

      // Vector table, applied from the reset state, one edge per record.
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));   // load 0
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));   // start with q==0 ignored
      vecs.push_back(mk(1, 5, 0, 0, 0, 5, 0, 0));   // load 5
      vecs.push_back(mk(0, 0, 1, 0, 0, 5, 1, 0));   // start, no decrement
      vecs.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));   // one-shot terminal
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));   // stays 0
      vecs.push_back(mk(1, 2, 0, 0, 0, 2, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 2, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(1, 7, 0, 0, 0, 7, 1, 0));   // load beats terminal count
      vecs.push_back(mk(0, 0, 0, 1, 0, 7, 1, 0));   // stop -> pause
      vecs.push_back(mk(0, 0, 1, 1, 0, 7, 1, 0));   // start+stop: stays paused
      vecs.push_back(mk(0, 0, 1, 0, 0, 7, 1, 0));   // resume, no decrement
      vecs.push_back(mk(0, 0, 0, 0, 0, 6, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));   // load 0 while running -> idle
      vecs.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1));   // R==1 periodic pulses every cycle
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));   // periodic dropped: one-shot end
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].ld, vecs[i].dv, vecs[i].st, vecs[i].sp, vecs[i].per);
         tick();
         chk($sformatf("vec%0d_q", i), int'(q), vecs[i].eq);
         chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].eb));
         chk($sformatf("vec%0d_tc", i), int'(tc), int'(vecs[i].et));
      end

      // Reset mid-count: asynchronous clear, no tc afterwards.
      do_reset();
      drive(1, 200, 0, 0, 0); tick();
      drive(0, 0, 1, 0, 0); tick();
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) tick();
      chk("pre_reset_q", int'(q), 190);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_q", int'(q), 0);
      chk("async_reset_busy", int'(busy), 0);
      chk("async_reset_tc", int'(tc), 0);
      tick();
      reset = 1'b0;
      seen_tc = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tc || busy || q != 0) seen_tc = 1;
      end
      chk("after_reset_quiet", int'(seen_tc), 0);

      // Periodic R=3: q 2,1,3,... with tc on each reload.
      do_reset();
      drive(1, 3, 0, 0, 1); tick();
      drive(0, 0, 1, 0, 1); tick();
      chk("per_start_q", int'(q), 3);
      drive(0, 0, 0, 0, 1);
      for (int i = 0; i < 9; i++) begin
         tick();
         chk($sformatf("per%0d_q", i), int'(q), 3 - ((i + 1) % 3));
         chk($sformatf("per%0d_tc", i), int'(tc), int'((i + 1) % 3 == 0));
         chk($sformatf("per%0d_busy", i), int'(busy), 1);
      end

      // Pause/resume: 10 loaded, stop at q=6 for 4 edges, tc delayed by 5 edges.
      do_reset();
      drive(1, 10, 0, 0, 0); tick();
      drive(0, 0, 1, 0, 0); tick();
      tc_edge = -1;
      for (int e = 1; e <= 40; e++) begin
         drive(0, 0, (e == 9), (e >= 5 && e <= 8), 0);
         tick();
         if (e >= 5 && e <= 9) begin
            chk($sformatf("pause_e%0d_q", e), int'(q), 6);
            chk($sformatf("pause_e%0d_busy", e), int'(busy), 1);
         end
         if (e == 10) chk("resume_q", int'(q), 5);
         if (tc && tc_edge < 0) tc_edge = e;
      end
      chk("pause_tc_edge", tc_edge, 15);

      // Full-width one-shot from 8'hFF: tc 255 edges after the start edge.
      do_reset();
      drive(1, 255, 0, 0, 0); tick();
      drive(0, 0, 1, 0, 0); tick();
      drive(0, 0, 0, 0, 0);
      tc_edge = -1;
      wrapped = 0;
      for (int e = 1; e <= 400 && tc_edge < 0; e++) begin
         tick();
         if (q == 8'hFF) wrapped = 1;
         if (tc) tc_edge = e;
      end
      chk("ff_tc_edge", tc_edge, 255);
      chk("ff_no_wrap", int'(wrapped), 0);
      chk("ff_end_q", int'(q), 0);

      // Random stimulus against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit ld, st, sp, per;
         int dv;
         ld  = ($urandom_range(0, 15) == 0);
         dv  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 255));
         st  = ($urandom_range(0, 3) == 0);
         sp  = ($urandom_range(0, 9) == 0);
         per = $urandom_range(0, 1);
         drive(ld, dv, st, sp, per);
         model_step(ld, dv, st, sp, per);
         tick();
         chk("rnd_q", int'(q), m_cnt);
         chk("rnd_busy", int'(busy), int'(m_mode != 0));
         chk("rnd_tc", int'(tc), int'(m_tc));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
